// File: rtl/sa_pkg.sv
// Shared definitions for the systolic-array edge buffers: skew mode encoding
// and the per-channel delay formula used by both RTL and verification.
package sa_pkg;

  typedef enum logic {
    SKEW_MODE   = 1'b0,
    DESKEW_MODE = 1'b1
  } skew_mode_e;

  // SKEW grows the delay with the channel index, DESKEW mirrors it.
  function automatic int delay_of(input int c, input int base, input int mode, input int nch);
    if (mode == int'(DESKEW_MODE)) return base + (nch - 1 - c);
    return base + c;
  endfunction

endpackage

// File: rtl/skew_buffer_delay_line.sv
// Single-channel delay line with stall and synchronous flush; DEPTH=0
// collapses to a plain wire that ignores clock, reset, stall and flush.
module delay_line #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  if (DEPTH == 0) begin : g_wire
    logic w_unused;
    assign w_unused = i_clk ^ i_rstn ^ i_en ^ i_clr;
    assign o_q      = i_d;
  end else begin : g_reg
    logic [WIDTH-1:0] r_stage [DEPTH];

    // Flush beats enable, so a sample presented together with clr is dropped.
    always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
        for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
      end else if (i_clr) begin
        for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
      end else if (i_en) begin
        r_stage[0] <= i_d;
        for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
      end
    end

    assign o_q = r_stage[DEPTH-1];
  end

endmodule

// File: rtl/skew_buffer.sv
// Multi-channel skew/deskew delay bank for systolic-array edges.
// Define SKEW_BUF_VALID_EN to add per-channel valid chains and an in-flight counter.
module skew_buffer
  import sa_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_CH     = 4,
  parameter int BASE_DELAY = 0,
  parameter int MODE       = 0
) (
  input  logic                         clk_i,
  input  logic                         rstn_i,
  input  logic                         en_i,
  input  logic                         clr_i,
  input  logic [NUM_CH*DATA_WIDTH-1:0] data_i,
`ifdef SKEW_BUF_VALID_EN
  input  logic [NUM_CH-1:0]            valid_i,
  output logic [NUM_CH-1:0]            valid_o,
  output logic                         busy_o,
`endif
  output logic [NUM_CH*DATA_WIDTH-1:0] data_o
);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    localparam int DLY = delay_of(c, BASE_DELAY, MODE, NUM_CH);

    delay_line #(
      .WIDTH (DATA_WIDTH),
      .DEPTH (DLY)
    ) u_data (
      .i_clk  (clk_i),
      .i_rstn (rstn_i),
      .i_en   (en_i),
      .i_clr  (clr_i),
      .i_d    (data_i[c*DATA_WIDTH +: DATA_WIDTH]),
      .o_q    (data_o[c*DATA_WIDTH +: DATA_WIDTH])
    );

`ifdef SKEW_BUF_VALID_EN
    delay_line #(
      .WIDTH (1),
      .DEPTH (DLY)
    ) u_valid (
      .i_clk  (clk_i),
      .i_rstn (rstn_i),
      .i_en   (en_i),
      .i_clr  (clr_i),
      .i_d    (valid_i[c]),
      .o_q    (valid_o[c])
    );
`endif
  end

`ifdef SKEW_BUF_VALID_EN
  localparam int CNT_W = $clog2(NUM_CH*(BASE_DELAY+NUM_CH)+1);

  function automatic logic [NUM_CH-1:0] delayed_mask();
    logic [NUM_CH-1:0] m;
    for (int c = 0; c < NUM_CH; c++) m[c] = (delay_of(c, BASE_DELAY, MODE, NUM_CH) > 0);
    return m;
  endfunction

  // Wire channels never hold a token, so only delayed channels are counted.
  localparam logic [NUM_CH-1:0] DLY_MASK = delayed_mask();

  logic [CNT_W-1:0] r_flight;
  logic [CNT_W-1:0] w_add;
  logic [CNT_W-1:0] w_sub;

  always_comb begin
    w_add = '0;
    w_sub = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      w_add = w_add + CNT_W'(valid_i[c] & DLY_MASK[c]);
      w_sub = w_sub + CNT_W'(valid_o[c] & DLY_MASK[c]);
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_flight <= '0;
    end else if (clr_i) begin
      r_flight <= '0;
    end else if (en_i) begin
      r_flight <= r_flight + w_add - w_sub;
    end
  end

  assign busy_o = (r_flight != '0);
`endif

endmodule

// File: tb/tb_skew_buffer.sv
// Directed and random checks of skew_buffer in SKEW, DESKEW and pure-wire
// configurations; valid/busy checks are active when SKEW_BUF_VALID_EN is defined.
module tb_skew_buffer;
   import sa_pkg::*;

   logic        clk;
   logic        rstn;
   logic        en;
   logic        clr;
   logic [31:0] data;
   logic [3:0]  valid;
   logic [31:0] skewData;
   logic [31:0] deskData;
   logic [7:0]  wireData;
   logic [3:0]  skewValid;
   logic [3:0]  deskValid;
   logic        wireValid;
   logic        skewBusy;
   logic        deskBusy;
   logic        wireBusy;

   int assertCount = 0;
   int failCount   = 0;

   // History of accepted samples, newest first; index k is what sits k+1 stages deep.
   logic [31:0] histData  [8];
   logic [3:0]  histValid [8];

   skew_buffer #(.DATA_WIDTH(8), .NUM_CH(4), .BASE_DELAY(0), .MODE(0)) u_skew (
      .clk_i   (clk),
      .rstn_i  (rstn),
      .en_i    (en),
      .clr_i   (clr),
      .data_i  (data),
`ifdef SKEW_BUF_VALID_EN
      .valid_i (valid),
      .valid_o (skewValid),
      .busy_o  (skewBusy),
`endif
      .data_o  (skewData)
   );

   skew_buffer #(.DATA_WIDTH(8), .NUM_CH(4), .BASE_DELAY(1), .MODE(1)) u_desk (
      .clk_i   (clk),
      .rstn_i  (rstn),
      .en_i    (en),
      .clr_i   (clr),
      .data_i  (data),
`ifdef SKEW_BUF_VALID_EN
      .valid_i (valid),
      .valid_o (deskValid),
      .busy_o  (deskBusy),
`endif
      .data_o  (deskData)
   );

   skew_buffer #(.DATA_WIDTH(8), .NUM_CH(1), .BASE_DELAY(0), .MODE(0)) u_wire (
      .clk_i   (clk),
      .rstn_i  (rstn),
      .en_i    (en),
      .clr_i   (clr),
      .data_i  (data[7:0]),
`ifdef SKEW_BUF_VALID_EN
      .valid_i (valid[0:0]),
      .valid_o (wireValid),
      .busy_o  (wireBusy),
`endif
      .data_o  (wireData)
   );

`ifndef SKEW_BUF_VALID_EN
   assign skewValid = '0;
   assign deskValid = '0;
   assign wireValid = 1'b0;
   assign skewBusy  = 1'b0;
   assign deskBusy  = 1'b0;
   assign wireBusy  = 1'b0;
`endif

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point: counts every check and reports any mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      assertCount++;
      if (obs !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic clearHistory();
      for (int k = 0; k < 8; k++) begin
         histData[k]  = '0;
         histValid[k] = '0;
      end
   endtask

   function automatic logic [31:0] expData(input int mode, input int base);
      logic [31:0] r;
      int d;
      r = '0;
      for (int c = 0; c < 4; c++) begin
         d = delay_of(c, base, mode, 4);
         r[c*8 +: 8] = (d == 0) ? data[c*8 +: 8] : histData[d-1][c*8 +: 8];
      end
      return r;
   endfunction

   function automatic logic [3:0] expValid(input int mode, input int base);
      logic [3:0] r;
      int d;
      r = '0;
      for (int c = 0; c < 4; c++) begin
         d = delay_of(c, base, mode, 4);
         r[c] = (d == 0) ? valid[c] : histValid[d-1][c];
      end
      return r;
   endfunction

   // A token counts as in flight while it occupies any stage of a delayed channel.
   function automatic logic expBusy(input int mode, input int base);
      logic b;
      int d;
      b = 1'b0;
      for (int c = 0; c < 4; c++) begin
         d = delay_of(c, base, mode, 4);
         for (int k = 0; k < d; k++) b = b | histValid[k][c];
      end
      return b;
   endfunction

   task automatic checkAll();
      checkOutput("skew_data", skewData, expData(0, 0));
      checkOutput("desk_data", deskData, expData(1, 1));
      checkOutput("wire_data", {24'h0, wireData}, {24'h0, data[7:0]});
`ifdef SKEW_BUF_VALID_EN
      checkOutput("skew_valid", {28'h0, skewValid}, {28'h0, expValid(0, 0)});
      checkOutput("desk_valid", {28'h0, deskValid}, {28'h0, expValid(1, 1)});
      checkOutput("wire_valid", {31'h0, wireValid}, {31'h0, valid[0]});
      checkOutput("skew_busy", {31'h0, skewBusy}, {31'h0, expBusy(0, 0)});
      checkOutput("desk_busy", {31'h0, deskBusy}, {31'h0, expBusy(1, 1)});
      checkOutput("wire_busy", {31'h0, wireBusy}, 32'h0);
`endif
   endtask

   // Drives one cycle of inputs, advances the history model at the edge, then checks.
   task automatic applyStimulus(input logic e, input logic c, input logic [31:0] d, input logic [3:0] v);
      en    = e;
      clr   = c;
      data  = d;
      valid = v;
      @(posedge clk);
      if (!rstn || c) begin
         clearHistory();
      end else if (e) begin
         for (int k = 7; k > 0; k--) begin
            histData[k]  = histData[k-1];
            histValid[k] = histValid[k-1];
         end
         histData[0]  = d;
         histValid[0] = v;
      end
      #1;
      checkAll();
   endtask

   initial begin
      rstn  = 1'b0;
      en    = 1'b1;
      clr   = 1'b0;
      data  = 32'hDDCCBBAA;
      valid = 4'h0;
      clearHistory();

      // Reset: wire channels follow input, delayed channels read zero.
      #3;
      checkOutput("rst_skew_data", skewData, 32'h000000AA);
      checkOutput("rst_desk_data", deskData, 32'h00000000);
      checkOutput("rst_wire_data", {24'h0, wireData}, 32'h000000AA);
`ifdef SKEW_BUF_VALID_EN
      checkOutput("rst_skew_valid", {28'h0, skewValid}, 32'h0);
      checkOutput("rst_skew_busy", {31'h0, skewBusy}, 32'h0);
`endif
      @(posedge clk);
      #1;
      rstn = 1'b1;

      // Triangular skew fill after reset release.
      applyStimulus(1'b1, 1'b0, 32'hDDCCBBAA, 4'h0);
      checkOutput("fill1", skewData, 32'h0000BBAA);
      applyStimulus(1'b1, 1'b0, 32'hDDCCBBAA, 4'h0);
      checkOutput("fill2", skewData, 32'h00CCBBAA);
      applyStimulus(1'b1, 1'b0, 32'hDDCCBBAA, 4'h0);
      checkOutput("fill3", skewData, 32'hDDCCBBAA);

      // DESKEW drain of a single all-valid injection.
      applyStimulus(1'b1, 1'b1, 32'h0, 4'h0);
      applyStimulus(1'b1, 1'b0, 32'h04030201, 4'hF);
      checkOutput("desk_t1", deskData, 32'h04000000);
      applyStimulus(1'b1, 1'b0, 32'h0, 4'h0);
      checkOutput("desk_t2", deskData, 32'h00030000);
      applyStimulus(1'b1, 1'b0, 32'h0, 4'h0);
      checkOutput("desk_t3", deskData, 32'h00000200);
      applyStimulus(1'b1, 1'b0, 32'h0, 4'h0);
      checkOutput("desk_t4", deskData, 32'h00000001);
`ifdef SKEW_BUF_VALID_EN
      checkOutput("desk_t4_valid", {28'h0, deskValid}, 32'h1);
      checkOutput("desk_t4_busy", {31'h0, deskBusy}, 32'h1);
`endif
      applyStimulus(1'b1, 1'b0, 32'h0, 4'h0);
      checkOutput("desk_t5", deskData, 32'h0);
`ifdef SKEW_BUF_VALID_EN
      checkOutput("desk_t5_busy", {31'h0, deskBusy}, 32'h0);
`endif

      // Stall for three cycles in the middle of an incrementing stream.
      applyStimulus(1'b1, 1'b1, 32'h0, 4'h0);
      for (int i = 0; i < 12; i++) begin
         applyStimulus(!(i >= 4 && i <= 6), 1'b0,
                       {8'(48 + i), 8'(32 + i), 8'(16 + i), 8'(i)}, 4'hF);
         if (i == 3) checkOutput("stall_pre", skewData, 32'h31221303);
         if (i == 6) checkOutput("stall_hold", skewData, 32'h31221306);
         if (i == 7) checkOutput("stall_resume", skewData, 32'h32231707);
      end

      // Flush with six tokens in flight and a competing enabled sample.
      applyStimulus(1'b1, 1'b1, 32'h0, 4'h0);
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 32'hA0A1A2A3 + 32'(i), 4'hF);
`ifdef SKEW_BUF_VALID_EN
      checkOutput("pre_clr_busy", {31'h0, skewBusy}, 32'h1);
`endif
      applyStimulus(1'b1, 1'b1, 32'h11223344, 4'hF);
      data  = 32'h0;
      valid = 4'h0;
      #1;
      checkOutput("clr_data", skewData, 32'h0);
`ifdef SKEW_BUF_VALID_EN
      checkOutput("clr_valid", {28'h0, skewValid}, 32'h0);
      checkOutput("clr_busy", {31'h0, skewBusy}, 32'h0);
`endif
      applyStimulus(1'b1, 1'b0, 32'h0, 4'h0);
      checkOutput("clr_dropped", skewData, 32'h0);

      // Random stream with occasional flushes.
      for (int i = 0; i < 1000; i++) begin
         applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0,
                       $urandom, 4'($urandom_range(0, 15)));
      end

      // Asynchronous reset in the middle of traffic clears immediately.
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 32'h55667788 + 32'(i), 4'hF);
      data = 32'h12345678;
      rstn = 1'b0;
      #1;
      clearHistory();
      checkOutput("async_rst_skew", skewData, 32'h00000078);
      checkOutput("async_rst_desk", deskData, 32'h0);
      checkAll();
      @(posedge clk);
      #1;
      rstn = 1'b1;
      applyStimulus(1'b1, 1'b0, 32'h0, 4'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
